uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin scheduler sharing the single UART TX byte path (TX FIFO write port) among
//  NUM_REQ on-chip byte-stream requesters. Grants one requester at a time, holds the grant for
//  a whole packet (until last), and forces rotation on burst limit, stall timeout or flush.
//  Sits between the requesters and the TX FIFO write side of the UART peripheral.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8)
//  MAX_BURST    16  max bytes transferred per grant before forced release (1..255)
//  STALL_LIMIT  64  consecutive cycles granted requester may hold req_valid low before release (1..255)
// PORTS
//  clk          in   1          clock
//  nReset       in   1          synchronous, active-low reset
//  req_valid    in   NUM_REQ    requester i has a byte on req_data[i]
//  req_data     in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//  req_last     in   NUM_REQ    byte of requester i is last of its packet
//  req_ready    out  NUM_REQ    byte of requester i accepted this cycle (one-hot or zero)
//  flush        in   1          abort current grant (e.g. on buffer clear)
//  tx_data      out  8          byte to TX FIFO wdata
//  tx_valid     out  1          TX FIFO WEN
//  tx_ready     in   1          TX FIFO not full
//  grant_id     out  clog2(NUM_REQ)  index of current/last granted requester
//  busy         out  1          a grant is active
//  rel_stall    out  1          1-cycle pulse: grant released by stall timeout
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer = NUM_REQ-1 (req 0 highest priority first), grant_id=0,
//    busy=0, rel_stall=0, burst/stall counters 0; tx_valid=0, req_ready=0 while IDLE.
//  - FSM IDLE -> GRANT: when flush=0 and any req_valid, select first set req_valid searching
//    ptr+1, ptr+2, ... wrapping mod NUM_REQ; grant_id/busy registered at the edge, so first
//    byte may transfer 1 cycle after request (arbitration latency 1 cycle). Flush=1 blocks grant.
//  - GRANT pass-through (combinational on registered grant g): tx_valid=req_valid[g],
//    tx_data=req_data[g], req_ready[g]=tx_ready & req_valid[g]; all other req_ready=0.
//  - Transfer = tx_valid & tx_ready. Each transfer increments 8-bit burst counter.
//  - GRANT -> IDLE (at edge) on any of: transfer with req_last[g]; transfer making burst count
//    == MAX_BURST; stall counter reaching STALL_LIMIT; flush=1. On release ptr<=g,
//    burst and stall counters <=0, busy<=0; grant_id holds g.
//  - Stall counter: in GRANT increments each cycle req_valid[g]=0, clears when req_valid[g]=1;
//    tx_ready=0 back-pressure never counts as stall. Stall release pulses rel_stall 1 cycle.
//  - Flush in same cycle as a transfer: the transfer completes (byte written), then release.
//    Flush has no effect on counters beyond release; flush while IDLE: no grant that cycle.
//  - Release and new grant never occur in the same edge: always >=1 IDLE cycle between grants.
//  - Requester dropping valid mid-packet keeps grant until stall timeout; others wait.
//  - Reset mid-packet: immediate return to reset state; partial packet is not completed.
//  - Counters saturate-free by construction (release at limit); widths 8 bits.
// TESTING
//  1 Reset, req_valid=4'b0101, tx_ready=1, 3-byte packets -> req0 granted 1 cycle later, 3 bytes,
//    1 idle cycle, then req2 granted; grant_id 0 then 2.
//  2 All 4 requesters continuously valid, 1-byte packets -> grant order 0,1,2,3,0,... no starvation.
//  3 req1 sends 20-byte packet, MAX_BURST=16 -> release after 16th byte, others served,
//    req1 later regranted for remaining 4 bytes.
//  4 Granted req0 drops valid for 64 cycles -> release, rel_stall pulse, req3 (waiting) granted;
//    tx_ready=0 for 100 cycles with valid high -> no release, no byte lost.
//  5 flush asserted on same cycle as byte transfer -> byte written once, busy=0 next cycle,
//    no grant while flush held.
//  6 nReset low mid-packet -> busy=0, tx_valid=0, req_ready=0 next cycle; req0 wins first after reset.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares the UART TX FIFO write port among NUM_REQ
// byte-stream requesters. A grant is held for a whole packet and is released
// early on burst limit, stall timeout or flush. At least one idle cycle always
// separates two grants.
//
// Handshake: a requester offers a byte by holding req_valid[i] with stable
// req_data/req_last until req_ready[i] is seen high in a cycle; that cycle is
// the transfer. On the FIFO side a byte is written in every cycle where
// tx_valid & tx_ready. The FIFO side never sees tx_valid without the granted
// requester's req_valid, and req_ready is only raised when tx_ready is high.
//
// busy is the registered FSM state (1 = GRANT) and serves as the state probe.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int STALL_LIMIT = 64,
    localparam int IdW        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 flush,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [IdW-1:0]       grant_id,
    output logic                 busy,
    output logic                 rel_stall
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState_e;

    arbState_e  state;
    arbState_e  nextState;
    logic [IdW-1:0] ptr;
    logic [IdW-1:0] grantId;
    logic [7:0] burstCnt;
    logic [7:0] stallCnt;
    logic       relStallQ;

    logic           selFound;
    logic [IdW-1:0] selIdx;
    logic           startGrant;
    logic           grantValid;
    logic           xfer;
    logic           lastRel;
    logic           burstRel;
    logic           stallRel;
    logic           relNow;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        int idx;
        idx      = 0;
        selFound = 1'b0;
        selIdx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!selFound && req_valid[idx]) begin
                selFound = 1'b1;
                selIdx   = IdW'(idx);
            end
        end
    end

    // Byte path: the granted requester is wired straight to the FIFO write port.
    always_comb begin
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        req_ready  = '0;
        grantValid = req_valid[grantId];
        if (state == GRANT) begin
            tx_valid           = grantValid;
            tx_data            = req_data[8*grantId +: 8];
            req_ready[grantId] = tx_ready & grantValid;
        end
    end

    // Release causes; the transferring byte always completes before release.
    always_comb begin
        xfer       = tx_valid & tx_ready;
        lastRel    = xfer & req_last[grantId];
        burstRel   = xfer & (burstCnt == 8'(MAX_BURST - 1));
        stallRel   = (state == GRANT) & ~grantValid & (stallCnt == 8'(STALL_LIMIT - 1));
        relNow     = lastRel | burstRel | stallRel | flush;
        startGrant = (state == IDLE) & ~flush & selFound;
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startGrant) nextState = GRANT;
            GRANT:   if (relNow) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State, grant, pointer and counter registers.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state     <= IDLE;
            ptr       <= IdW'(NUM_REQ - 1);
            grantId   <= '0;
            burstCnt  <= 8'd0;
            stallCnt  <= 8'd0;
            relStallQ <= 1'b0;
        end else begin
            state     <= nextState;
            relStallQ <= 1'b0;
            if (state == IDLE) begin
                burstCnt <= 8'd0;
                stallCnt <= 8'd0;
                if (startGrant) grantId <= selIdx;
            end else if (relNow) begin
                ptr       <= grantId;
                burstCnt  <= 8'd0;
                stallCnt  <= 8'd0;
                relStallQ <= stallRel;
            end else begin
                if (xfer) burstCnt <= burstCnt + 8'd1;
                stallCnt <= grantValid ? 8'd0 : stallCnt + 8'd1;
            end
        end
    end

    assign grant_id  = grantId;
    assign busy      = (state == GRANT);
    assign rel_stall = relStallQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester sources with per-requester expected
// byte queues, a grant/length log, a table of arbitration vectors and
// hand-written sequences for burst, stall, back-pressure, flush and reset.
module tb_uart_tx_arbiter;

    localparam int NumReq = 4;

    logic        clk = 1'b0;
    logic        nReset;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqLast;
    logic [3:0]  reqReady;
    logic        flush;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [1:0]  grantId;
    logic        busy;
    logic        relStall;

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(16), .STALL_LIMIT(64)) dut (
        .clk(clk), .nReset(nReset),
        .req_valid(reqValid), .req_data(reqData), .req_last(reqLast), .req_ready(reqReady),
        .flush(flush),
        .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
        .grant_id(grantId), .busy(busy), .rel_stall(relStall)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int nChecks = 0;
    int nPass   = 0;

    // Source model state
    int         srcLeft[NumReq];
    int         srcSeq[NumReq];
    logic       srcOn[NumReq];
    logic [3:0] accepted;
    logic       randReady;

    // Scoreboard: expected bytes per requester
    logic [7:0] expQ[NumReq][$];

    // Monitor state
    int   grantLog[$];
    int   lenLog[$];
    int   curLen;
    int   relCount;
    logic prevBusy;
    int   prevGid;
    logic sampBusy;
    logic sampTxValid;
    logic [3:0] sampReady;
    int   sampGid;
    logic sampRel;

    typedef struct packed {
        logic [3:0] mask;
        logic [2:0] n;
        logic [7:0] order;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int got, input int exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [7:0] byteOf(input int i, input int s);
        return {i[1:0], s[5:0]};
    endfunction

    function automatic logic [7:0] ord4(input int a, input int b, input int c, input int d);
        return {d[1:0], c[1:0], b[1:0], a[1:0]};
    endfunction

    function automatic logic pending();
        logic p;
        p = 1'b0;
        for (int i = 0; i < NumReq; i++) if (srcLeft[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic driveOutputs();
        for (int i = 0; i < NumReq; i++) begin
            reqValid[i]        = srcOn[i] && (srcLeft[i] > 0);
            reqData[8*i +: 8]  = byteOf(i, srcSeq[i]);
            reqLast[i]         = (srcLeft[i] == 1);
        end
    endtask

    // Driver: load a packet into source i and queue its bytes as expected output
    task automatic sendPkt(input int i, input int len);
        for (int k = 0; k < len; k++) expQ[i].push_back(byteOf(i, srcSeq[i] + k));
        srcLeft[i] = len;
        driveOutputs();
    endtask

    // One clock: sample and check on the falling edge, advance sources after the rising edge
    task automatic tick();
        int g;
        logic [7:0] e;
        @(negedge clk);
        g           = int'(grantId);
        sampBusy    = busy;
        sampTxValid = txValid;
        sampReady   = reqReady;
        sampGid     = g;
        sampRel     = relStall;
        if (busy && !prevBusy) grantLog.push_back(g);
        if (busy && prevBusy) check("grant_stable", g, prevGid);
        if (!busy && prevBusy) begin
            lenLog.push_back(curLen);
            curLen = 0;
        end
        if (txValid && txReady) begin
            curLen++;
            check("ready_onehot", int'(reqReady), 1 << g);
            if (expQ[g].size() == 0) begin
                nChecks++;
                $display("FAIL sb_empty: req %0d wrote %h, nothing expected", g, txData);
            end else begin
                e = expQ[g].pop_front();
                check("sb_byte", int'(txData), int'(e));
            end
        end else if (!busy) begin
            check("idle_quiet", int'({txValid, reqReady}), 0);
        end
        if (relStall) relCount++;
        accepted = reqReady;
        prevBusy = busy;
        prevGid  = g;
        @(posedge clk);
        #1;
        for (int i = 0; i < NumReq; i++) begin
            if (accepted[i]) begin
                srcLeft[i]--;
                srcSeq[i]++;
            end
        end
        if (randReady) txReady = ($urandom_range(0, 3) != 0);
        driveOutputs();
    endtask

    task automatic drain(input int bound);
        int c;
        c = 0;
        while ((pending() || sampBusy) && c < bound) begin
            tick();
            c++;
        end
        if (pending() || sampBusy) begin
            nChecks++;
            $display("FAIL drain_timeout: still active after %0d cycles", bound);
        end
        randReady = 1'b0;
        txReady   = 1'b1;
    endtask

    task automatic clearLogs();
        grantLog.delete();
        lenLog.delete();
        curLen   = 0;
        relCount = 0;
    endtask

    task automatic checkLogs(input string name, input logic [63:0] expG, input int nG,
                             input logic [63:0] expL, input int nL);
        check({name, "_ngrant"}, grantLog.size(), nG);
        for (int k = 0; k < nG; k++)
            check({name, "_gid"}, (k < grantLog.size()) ? grantLog[k] : -1, int'(expG[8*k +: 8]));
        check({name, "_nlen"}, lenLog.size(), nL);
        for (int k = 0; k < nL; k++)
            check({name, "_len"}, (k < lenLog.size()) ? lenLog[k] : -1, int'(expL[8*k +: 8]));
    endtask

    task automatic doReset();
        nReset    = 1'b0;
        flush     = 1'b0;
        txReady   = 1'b1;
        randReady = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            srcLeft[i] = 0;
            srcOn[i]   = 1'b1;
            expQ[i].delete();
        end
        driveOutputs();
        tick();
        tick();
        nReset = 1'b1;
        clearLogs();
    endtask

    initial begin
        int c;
        for (int i = 0; i < NumReq; i++) srcSeq[i] = 0;
        prevBusy = 1'b0;
        prevGid  = 0;
        sampBusy = 1'b0;
        accepted = '0;
        curLen   = 0;
        relCount = 0;

        // Arbitration vectors from reset (pointer starts at 3); 1-byte packets each
        vecs[0] = '{4'b0101, 3'd2, ord4(0, 2, 0, 0)};
        vecs[1] = '{4'b1111, 3'd4, ord4(3, 0, 1, 2)};
        vecs[2] = '{4'b0011, 3'd2, ord4(0, 1, 0, 0)};
        vecs[3] = '{4'b1001, 3'd2, ord4(3, 0, 0, 0)};
        vecs[4] = '{4'b0100, 3'd1, ord4(2, 0, 0, 0)};
        vecs[5] = '{4'b1110, 3'd3, ord4(3, 1, 2, 0)};
        vecs[6] = '{4'b0110, 3'd2, ord4(1, 2, 0, 0)};
        vecs[7] = '{4'b1011, 3'd3, ord4(3, 0, 1, 0)};

        // Reset state
        doReset();
        tick();
        check("rst_busy", int'(sampBusy), 0);
        check("rst_txvalid", int'(sampTxValid), 0);
        check("rst_ready", int'(sampReady), 0);
        check("rst_gid", sampGid, 0);
        check("rst_relstall", int'(sampRel), 0);

        // Table-driven arbitration order
        for (int v = 0; v < 8; v++) begin
            clearLogs();
            for (int i = 0; i < NumReq; i++) if (vecs[v].mask[i]) sendPkt(i, 1);
            drain(100);
            check("vec_ngrants", grantLog.size(), int'(vecs[v].n));
            for (int k = 0; k < int'(vecs[v].n); k++)
                check("vec_order", (k < grantLog.size()) ? grantLog[k] : -1, int'(vecs[v].order[2*k +: 2]));
        end

        // Two 3-byte packets: 1-cycle latency, one idle cycle between grants
        doReset();
        sendPkt(0, 3);
        sendPkt(2, 3);
        begin
            logic [8:0] busyExp;
            busyExp = 9'b011101110;
            for (int k = 0; k < 9; k++) begin
                tick();
                check("pkt_busy_trace", int'(sampBusy), int'(busyExp[8-k]));
            end
        end
        drain(50);
        checkLogs("pkt", 64'h0200, 2, 64'h0303, 2);

        // Burst limit with random back-pressure: req1 20 bytes split 16 + 4
        doReset();
        sendPkt(1, 20);
        sendPkt(0, 1);
        sendPkt(2, 1);
        randReady = 1'b1;
        drain(400);
        checkLogs("burst", 64'h01020100, 4, 64'h04011001, 4);

        // Stall timeout: req0 goes quiet after one byte, req3 waits
        doReset();
        sendPkt(0, 5);
        tick();
        tick();
        srcOn[0] = 1'b0;
        sendPkt(3, 1);
        c = 0;
        do begin
            tick();
            c++;
        end while (sampBusy && c < 200);
        check("stall_cycles", c, 65);
        check("stall_pulse", int'(sampRel), 1);
        tick();
        check("stall_pulse_end", int'(sampRel), 0);
        check("stall_next_busy", int'(sampBusy), 1);
        check("stall_next_gid", sampGid, 3);
        srcOn[0] = 1'b1;
        driveOutputs();
        drain(100);
        check("stall_relcount", relCount, 1);
        checkLogs("stall", 64'h000300, 3, 64'h040101, 3);

        // Long back-pressure with valid high: no release, nothing lost
        doReset();
        txReady = 1'b0;
        sendPkt(0, 3);
        for (int k = 0; k < 100; k++) tick();
        check("bp_busy", int'(sampBusy), 1);
        check("bp_relcount", relCount, 0);
        check("bp_pending", expQ[0].size(), 3);
        txReady = 1'b1;
        drain(50);
        checkLogs("bp", 64'h00, 1, 64'h03, 1);

        // Flush coinciding with a transfer, then held while requests wait
        doReset();
        sendPkt(1, 4);
        sendPkt(2, 1);
        tick();
        tick();
        flush = 1'b1;
        tick();
        check("flush_xfer_busy", int'(sampBusy), 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("flush_hold_busy", int'(sampBusy), 0);
        end
        check("flush_left", expQ[1].size(), 2);
        flush = 1'b0;
        drain(100);
        checkLogs("flush", 64'h010201, 3, 64'h020102, 3);

        // Reset in the middle of req1's packet
        doReset();
        sendPkt(1, 5);
        tick();
        tick();
        tick();
        nReset = 1'b0;
        tick();
        tick();
        check("midrst_busy", int'(sampBusy), 0);
        check("midrst_txvalid", int'(sampTxValid), 0);
        check("midrst_ready", int'(sampReady), 0);
        check("midrst_gid", sampGid, 0);
        srcLeft[1] = 0;
        expQ[1].delete();
        nReset = 1'b1;
        clearLogs();
        sendPkt(1, 2);
        sendPkt(0, 1);
        drain(100);
        checkLogs("midrst", 64'h0100, 2, 64'h0201, 2);

        // Nothing left unwritten
        begin
            int left;
            left = 0;
            for (int i = 0; i < NumReq; i++) left += expQ[i].size();
            check("sb_drained", left, 0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
